pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline: global run/idle, load-use stalls and control-transfer flushes.
//  Sits beside the pipeline. Drives the per-stage enable/flush inputs of the IF/ID, ID/EX and
//  EX/MEM registers and the PC enable. Observes ID operands, the EX load destination and the MEM
//  branch/jump resolution.
// PARAMETERS
//  LOAD_STALL  1   bubbles inserted per load-use hazard (1..7)
//  CNT_W       32  width of performance counters (used only with PERF_CNT_EN)
// PORTS
//  clk           in   1      main clock, rising edge
//  arst_n        in   1      asynchronous active-low reset
//  enable        in   1      run request from top level
//  id_rs         in   5      instruction[25:21] in ID
//  id_rt         in   5      instruction[20:16] in ID
//  id_uses_rt    in   1      ID instruction reads rt (R-type, sw, beq)
//  ex_mem_read   in   1      EX instruction is a load
//  ex_rt         in   5      load destination (instruction[20:16]) in EX
//  mem_branch    in   1      branch control bit in MEM
//  mem_zero      in   1      ALU zero flag in MEM
//  mem_jump      in   1      jump control bit in MEM
//  pc_en         out  1      PC update enable
//  if_id_en      out  1      IF/ID register enable
//  id_ex_en      out  1      ID/EX register enable
//  ex_mem_en     out  1      EX/MEM and MEM/WB register enable
//  if_id_flush   out  1      load zeros into IF/ID (nop)
//  id_ex_flush   out  1      load zeros into ID/EX (bubble)
//  ex_mem_flush  out  1      load zeros into EX/MEM
//  state_o       out  2      current FSM state (IDLE=0, RUN=1, STALL=2, FLUSH=3)
//  stall_cnt     out  CNT_W  bubbles inserted (PERF_CNT_EN only)
//  flush_cnt     out  CNT_W  redirects taken (PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE, stall counter=0, all enables and flushes 0; counters 0.
//  - Outputs are combinational from the registered state plus the current inputs. There is no
//    extra latency: a hazard is acted on in the same cycle it is visible.
//  - redirect = (mem_branch & mem_zero) | mem_jump
//  - hazard = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))
//  - IDLE:
//    - All enables 0, all flushes 0.
//    - enable=1 -> RUN next cycle. The first RUN cycle evaluates hazards normally.
//  - RUN:
//    - All enables 1.
//    - If redirect: assert if_id_flush, id_ex_flush and ex_mem_flush; pc_en=1 so the PC loads
//      the target; next state FLUSH.
//    - Else if hazard: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; load the stall counter
//      with LOAD_STALL-1; next state STALL if LOAD_STALL>1, else stay in RUN.
//  - STALL:
//    - Outputs as in the hazard case of RUN; the counter decrements each cycle.
//    - At 0 -> RUN.
//    - A redirect in STALL takes priority: flushes as in RUN, counter cleared, next state FLUSH.
//  - FLUSH:
//    - One cycle. All enables 1, no flushes; it lets the target fetch enter IF/ID.
//    - Next state RUN. Hazard and redirect inputs are ignored in this cycle.
//  - Redirect beats hazard when both occur in the same cycle.
//  - Flush beats enable on the same register.
//  - enable falling in any state:
//    - Next state IDLE, stall counter cleared, no flush issued.
//    - That cycle's outputs are already those of IDLE (all enables 0), so the pipeline freezes
//      with its contents intact.
//  - An asynchronous reset mid-operation returns to the reset values immediately.
//  - Stall counter is 3 bits. LOAD_STALL outside 1..7 is a compile-time error.
// CONFIGURATION
//  - PIPELINE_PERF_CNT_EN defined:
//    - stall_cnt increments once per cycle with id_ex_flush due to a hazard.
//    - flush_cnt increments once per redirect.
//    - Both saturate at all-ones and hold while in IDLE.
//  - PIPELINE_PERF_CNT_EN undefined: stall_cnt and flush_cnt are tied to 0 and no counter
//    flops are built.
// TESTING
//  - Reset, enable=0 for 5 cycles -> state_o=0 and every enable 0. Raise enable ->
//    state_o=1 next cycle, all enables 1.
//  - ex_mem_read=1, ex_rt=8, id_rs=8, LOAD_STALL=1 -> one cycle with pc_en=0, if_id_en=0,
//    id_ex_flush=1, then back to normal; stall_cnt=1.
//  - ex_rt=0 with id_rs=0, or ex_rt=9 with id_rt=9 and id_uses_rt=0 -> no stall.
//  - LOAD_STALL=3 with a hazard -> exactly 3 bubble cycles, state_o goes 2 then back to 1.
//    Redirect in the 2nd bubble -> all three flushes asserted, state_o=3, then 1.
//  - mem_branch=1, mem_zero=1 together with a hazard -> flushes asserted, no stall;
//    flush_cnt=1. With mem_zero=0 -> no flush.
//  - enable dropped during STALL -> all enables 0 in that cycle, state_o=0 next. Re-enable ->
//    RUN, hazard re-detected from the live inputs.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   This block sequences a classic 5-stage pipeline. It controls the global
//   run/idle state, inserts bubbles on load-use hazards, and flushes the
//   pipeline when a branch or jump resolves in MEM.
//
//   Outputs are combinational from the registered FSM state and the current
//   inputs. A hazard or redirect therefore acts in the same cycle it appears.
//
//   Optional feature: define PIPELINE_PERF_CNT_EN to build the two saturating
//   performance counters. When it is undefined, stall_cnt and flush_cnt are
//   tied to zero and no counter flops are built.
//
// Parameters
//   LOAD_STALL  bubbles inserted per load-use hazard (1..7)
//   CNT_W       performance counter width
//
// Ports
//   clk, arst_n          clock (rising edge), asynchronous active-low reset
//   enable               run request
//   id_rs, id_rt         source register fields of the instruction in ID
//   id_uses_rt           ID instruction reads rt
//   ex_mem_read, ex_rt   load in EX and its destination register
//   mem_branch, mem_zero,
//   mem_jump             control-transfer resolution in MEM
//   pc_en, *_en          PC and pipeline register enables
//   *_flush              zero-load of pipeline registers
//   state_o              IDLE=0, RUN=1, STALL=2, FLUSH=3
//   stall_cnt, flush_cnt performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The bubble counter is 3 bits wide, so larger values cannot be represented.
  if ((LOAD_STALL < 1) || (LOAD_STALL > 7)) begin : g_bad_load_stall
    $error("pipeline_ctrl: LOAD_STALL must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // The bubble issued by RUN is the first one, so the counter holds the
  // number of bubbles that remain after it.
  localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL - 1);
  localparam bit         MULTI_STALL = (LOAD_STALL > 1);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       redirect;
  logic       hazard;

  assign redirect = (mem_branch & mem_zero) | mem_jump;
  assign hazard   = ex_mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    if (!enable) begin
      // Freeze: the outputs stay at the IDLE values so the pipeline holds its contents.
      state_next = IDLE;
      cnt_next   = 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = RUN;
        end

        RUN: begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = FLUSH;
          end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            cnt_next    = STALL_LOAD;
            state_next  = MULTI_STALL ? STALL : RUN;
          end
        end

        STALL: begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_next     = 3'd0;
            state_next   = FLUSH;
          end else begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            cnt_next    = cnt_reg - 3'd1;
            if (cnt_reg <= 3'd1) begin
              cnt_next   = 3'd0;
              state_next = RUN;
            end
          end
        end

        FLUSH: begin
          // This cycle lets the target fetch enter IF/ID. Hazard and redirect inputs are ignored here.
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          state_next = RUN;
        end

        default: begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  assign state_o = state_reg;

`ifdef PIPELINE_PERF_CNT_EN
  logic             stall_evt;
  logic             redirect_evt;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // A hazard bubble flushes only ID/EX. A redirect flushes all three registers.
  assign stall_evt    = id_ex_flush & ~if_id_flush;
  assign redirect_evt = ex_mem_flush;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (redirect_evt && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
